// File: rtl/adcfifo_ctrl.sv
// ADC sample FIFO controller: drives a 64x16 two-port RAM and hides its 1-cycle
// read latency behind a 2-entry first-word-fall-through output stage.
module adcfifo_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int AFULL_LEVEL = 48
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CLR,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  FULL,
  output logic                  AFULL,
  output logic                  OVERFLOW,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic [DATA_WIDTH-1:0] RAM_WD,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic                  RAM_WEN,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR,
  output logic                  RAM_REN,
  input  logic [DATA_WIDTH-1:0] RAM_RD
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] RAM_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_THR = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   ram_cnt, count, count_nxt;
  logic                  inflight, overflow, afull;
  logic [1:0]            stage_cnt, held, pending;
  logic [DATA_WIDTH-1:0] stage0, stage1;
  logic                  full, accept, pop, issue;

  assign held    = stage_cnt + {1'b0, inflight};
  assign pop     = (stage_cnt != 2'd0) & RD_READY;
  assign pending = held - {1'b0, pop};
  assign full    = (ram_cnt == RAM_FULL) && (held == 2'd2);
  // Writes are blocked while reset is held so the RAM never sees a stray push.
  assign accept  = WE & ~full & ~CLR & RESET_N;
  assign issue   = ~CLR & (ram_cnt != '0) & (pending < 2'd2);

  always_comb begin
    count_nxt = count + (ADDR_WIDTH+1)'(accept) - (ADDR_WIDTH+1)'(pop);
    if (CLR) count_nxt = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      stage_cnt <= 2'd0;
      stage0    <= '0;
      stage1    <= '0;
      overflow  <= 1'b0;
      count     <= '0;
      afull     <= 1'b0;
    end else if (CLR) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      stage_cnt <= 2'd0;
      overflow  <= 1'b0;
      count     <= '0;
      afull     <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + ADDR_WIDTH'(1);
      if (issue)  rptr <= rptr + ADDR_WIDTH'(1);
      ram_cnt  <= ram_cnt + (ADDR_WIDTH+1)'(accept) - (ADDR_WIDTH+1)'(issue);
      inflight <= issue;
      if (WE & full) overflow <= 1'b1;
      count <= count_nxt;
      afull <= (count_nxt >= AFULL_THR);
      // The issue rule guarantees a capture never lands on a full stage.
      case ({inflight, pop})
        2'b01: begin
          stage0    <= stage1;
          stage_cnt <= stage_cnt - 2'd1;
        end
        2'b10: begin
          if (stage_cnt == 2'd0) stage0 <= RAM_RD;
          else                   stage1 <= RAM_RD;
          stage_cnt <= stage_cnt + 2'd1;
        end
        2'b11: begin
          if (stage_cnt == 2'd1) begin
            stage0 <= RAM_RD;
          end else begin
            stage0 <= stage1;
            stage1 <= RAM_RD;
          end
        end
        default: ;
      endcase
    end
  end

  assign FULL      = full;
  assign AFULL     = afull;
  assign OVERFLOW  = overflow;
  assign RD_VALID  = (stage_cnt != 2'd0);
  assign RD_DATA   = stage0;
  assign COUNT     = count;
  assign RAM_WD    = DATA_IN;
  assign RAM_WADDR = wptr;
  assign RAM_WEN   = accept;
  assign RAM_RADDR = rptr;
  assign RAM_REN   = issue;

endmodule

// File: tb/tb_adcfifo_ctrl.sv
// Directed bench for adcfifo_ctrl with a behavioural 64x16 RAM attached.
module tb_adcfifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clr, we, rd_ready;
  logic [15:0] din;
  logic        full, afull, overflow, rd_valid;
  logic [15:0] rd_data;
  logic [6:0]  count;
  logic [15:0] ram_wd, ram_rd;
  logic [5:0]  ram_waddr, ram_raddr;
  logic        ram_wen, ram_ren;
  logic [15:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    if (ram_ren) ram_rd <= mem[ram_raddr];
  end

  adcfifo_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .CLR(clr), .WE(we), .DATA_IN(din),
    .FULL(full), .AFULL(afull), .OVERFLOW(overflow), .RD_VALID(rd_valid),
    .RD_READY(rd_ready), .RD_DATA(rd_data), .COUNT(count),
    .RAM_WD(ram_wd), .RAM_WADDR(ram_waddr), .RAM_WEN(ram_wen),
    .RAM_RADDR(ram_raddr), .RAM_REN(ram_ren), .RAM_RD(ram_rd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; rd_ready = 1'b0; din = 16'h0;
    #12;
    checks++;
    if ({full, afull, overflow, rd_valid, ram_wen, ram_ren} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {full, afull, overflow, rd_valid, ram_wen, ram_ren});
    end
    checks++;
    if (count !== 7'd0 || rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_count_data: got count=%0d data=%h expected 0/0000", count, rd_data);
    end
    checks++;
    if (ram_waddr !== 6'd0 || ram_raddr !== 6'd0) begin
      errors++;
      $display("FAIL reset_addr: got waddr=%0d raddr=%0d expected 0/0", ram_waddr, ram_raddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    we = 1'b1; din = 16'h1234; rd_ready = 1'b1;
    #1;
    checks++;
    if (ram_wen !== 1'b1 || ram_waddr !== 6'd0) begin
      errors++;
      $display("FAIL single_wen: got wen=%b waddr=%0d expected 1/0", ram_wen, ram_waddr);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (ram_ren !== 1'b1 || ram_raddr !== 6'd0 || count !== 7'd1) begin
      errors++;
      $display("FAIL single_ren: got ren=%b raddr=%0d count=%0d expected 1/0/1", ram_ren, ram_raddr, count);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %b expected 0", rd_valid);
    end
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL single_out: got valid=%b data=%h expected 1/1234", rd_valid, rd_data);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL single_empty: got valid=%b count=%0d expected 0/0", rd_valid, count);
    end
  endtask

  task automatic test_fill_overflow();
    rd_ready = 1'b0;
    for (int i = 0; i < 66; i++) begin
      we = 1'b1; din = 16'(i);
      step();
      checks++;
      if (count !== 7'(i + 1) || afull !== (i + 1 >= 48) || full !== (i + 1 == 66)) begin
        errors++;
        $display("FAIL fill_%0d: got count=%0d afull=%b full=%b expected %0d/%b/%b",
                 i, count, afull, full, i + 1, (i + 1 >= 48), (i + 1 == 66));
      end
    end
    din = 16'hDEAD;
    #1;
    checks++;
    if (ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL fill_drop_wen: got %b expected 0", ram_wen);
    end
    step();
    we = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 7'd66 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: got ovf=%b count=%0d full=%b expected 1/66/1", overflow, count, full);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 66; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(k)) begin
        errors++;
        $display("FAIL drain_%0d: got valid=%b data=%h expected 1/%h", k, rd_valid, rd_data, 16'(k));
      end
      step();
    end
    checks++;
    if (rd_valid !== 1'b0 || count !== 7'd0 || full !== 1'b0 || afull !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: got valid=%b count=%0d full=%b afull=%b ovf=%b expected 0/0/0/0/1",
               rd_valid, count, full, afull, overflow);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int exp_out = 0;
    rd_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (rd_valid) begin
        checks++;
        if (rd_data !== 16'(32'h4000 + exp_out)) begin
          errors++;
          $display("FAIL stream_data: got %h expected %h", rd_data, 16'(32'h4000 + exp_out));
        end
        exp_out++;
      end
      if (c >= 3) begin
        checks++;
        if (rd_valid !== 1'b1 || count > 7'd3 || full !== 1'b0) begin
          errors++;
          $display("FAIL stream_steady_%0d: got valid=%b count=%0d full=%b expected 1/<=3/0", c, rd_valid, count, full);
        end
      end
      we = 1'b1; din = 16'(32'h4000 + c);
      step();
    end
    we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rd_valid) begin
        checks++;
        if (rd_data !== 16'(32'h4000 + exp_out)) begin
          errors++;
          $display("FAIL stream_tail: got %h expected %h", rd_data, 16'(32'h4000 + exp_out));
        end
        exp_out++;
      end
      step();
    end
    checks++;
    if (exp_out != 300 || count !== 7'd0) begin
      errors++;
      $display("FAIL stream_total: got words=%0d count=%0d expected 300/0", exp_out, count);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] sbq[$];
    int          mcount = 0;
    int          cyc = 0;
    int          next_val = 16'h7000;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic        acc, pp;
    while (mcount < 66 && cyc < 2000) begin
      checks++;
      if (count !== 7'(mcount) || full !== (mcount == 66)) begin
        errors++;
        $display("FAIL bp_count: got count=%0d full=%b expected %0d/%b", count, full, mcount, (mcount == 66));
      end
      if (prev_stall) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          errors++;
          $display("FAIL bp_stall: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, prev_data);
        end
      end
      if (rd_valid) begin
        checks++;
        if (sbq.size() == 0 || rd_data !== sbq[0]) begin
          errors++;
          $display("FAIL bp_data: got %h expected %h", rd_data, (sbq.size() == 0) ? 16'hxxxx : sbq[0]);
        end
      end
      rd_ready = 1'($urandom_range(0, 1));
      we = 1'b1; din = 16'(next_val);
      acc = (mcount != 66);
      pp  = rd_valid & rd_ready;
      if (acc) begin sbq.push_back(din); next_val++; mcount++; end
      if (pp && sbq.size() > 0) begin void'(sbq.pop_front()); mcount--; end
      prev_stall = rd_valid & ~rd_ready;
      prev_data  = rd_data;
      step();
      cyc++;
    end
    we = 1'b0;
    checks++;
    if (mcount != 66 || full !== 1'b1 || count !== 7'd66) begin
      errors++;
      $display("FAIL bp_fill: got model=%0d full=%b count=%0d expected 66/1/66", mcount, full, count);
    end
    rd_ready = 1'b1;
    cyc = 0;
    while (sbq.size() > 0 && cyc < 100) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== sbq[0]) begin
        errors++;
        $display("FAIL bp_drain: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, sbq[0]);
      end
      if (rd_valid) void'(sbq.pop_front());
      step();
      cyc++;
    end
    checks++;
    if (sbq.size() != 0 || count !== 7'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got left=%0d count=%0d valid=%b expected 0/0/0", sbq.size(), count, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_clr();
    int waited = 0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL clr_pre: got ovf=%b count=%0d expected 0/0", overflow, count);
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; din = 16'(32'h0100 + i);
      step();
    end
    we = 1'b0;
    step(); step();
    rd_ready = 1'b1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0100) begin
      errors++;
      $display("FAIL clr_head: got valid=%b data=%h expected 1/0100", rd_valid, rd_data);
    end
    step();
    rd_ready = 1'b0;
    clr = 1'b1; we = 1'b1; din = 16'h0BAD;
    #1;
    checks++;
    if (ram_ren !== 1'b0 || ram_wen !== 1'b0 || count !== 7'd19) begin
      errors++;
      $display("FAIL clr_block: got ren=%b wen=%b count=%0d expected 0/0/19", ram_ren, ram_wen, count);
    end
    step();
    clr = 1'b0; we = 1'b0;
    checks++;
    if (count !== 7'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || full !== 1'b0 || afull !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: got count=%0d valid=%b ovf=%b full=%b afull=%b expected 0/0/0/0/0",
               count, rd_valid, overflow, full, afull);
    end
    we = 1'b1; din = 16'hBEEF; rd_ready = 1'b1;
    #1;
    checks++;
    if (ram_waddr !== 6'd0) begin
      errors++;
      $display("FAIL clr_waddr: got %0d expected 0", ram_waddr);
    end
    step();
    we = 1'b0;
    while (!rd_valid && waited < 8) begin
      step();
      waited++;
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL clr_first_out: got valid=%b data=%h expected 1/beef", rd_valid, rd_data);
    end
    step();
    checks++;
    if (count !== 7'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_final: got count=%0d valid=%b expected 0/0", count, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    rd_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      we = 1'b1; din = 16'(32'h5000 + c);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({full, afull, overflow, rd_valid, ram_wen, ram_ren} !== 6'b0 || count !== 7'd0 ||
        rd_data !== 16'h0 || ram_waddr !== 6'd0 || ram_raddr !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b count=%0d data=%h waddr=%0d raddr=%0d expected all zero",
               {full, afull, overflow, rd_valid, ram_wen, ram_ren}, count, rd_data, ram_waddr, ram_raddr);
    end
    we = 1'b0; rd_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (count !== 7'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_post: got count=%0d valid=%b expected 0/0", count, rd_valid);
    end
    we = 1'b1; din = 16'hA5A5; rd_ready = 1'b1;
    #1;
    checks++;
    if (ram_wen !== 1'b1 || ram_waddr !== 6'd0) begin
      errors++;
      $display("FAIL async_push: got wen=%b waddr=%0d expected 1/0", ram_wen, ram_waddr);
    end
    step();
    we = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_early: got valid=%b expected 0", rd_valid);
    end
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin
      errors++;
      $display("FAIL async_out: got valid=%b data=%h expected 1/a5a5", rd_valid, rd_data);
    end
    step();
    checks++;
    if (count !== 7'd0) begin
      errors++;
      $display("FAIL async_end: got count=%0d expected 0", count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_streaming();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
